// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency 128-bit line memory answering instruction-cache requests.
// Define IMEM_RESP_WRITE_EN to enable line writes; otherwise every request is serviced as a read.
module instr_mem_responder #(
    parameter int LATENCY    = 5,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqI_mem,
    input  logic [19:0]  reqAddrI_mem,
    input  logic         req_write,
    input  logic [127:0] write_data,
    output logic [127:0] instr_from_mem,
    output logic         read_ready_from_mem,
    output logic         written_data_ack_from_mem,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic [DEPTH_LOG2-1:0] idx, req_idx, rd_idx;
    logic wr_q, req_wr, accept, fire, load_rd;
    logic [127:0] wdata_q;
    logic [127:0] mem [2**DEPTH_LOG2];
    logic unused_addr;
`ifdef IMEM_RESP_WRITE_EN
    assign req_wr = req_write;
`else
    logic unused_wr;
    assign req_wr = 1'b0;
    assign unused_wr = req_write;
`endif
    assign req_idx = reqAddrI_mem[DEPTH_LOG2+3:4];
    assign unused_addr = ^{reqAddrI_mem[3:0], reqAddrI_mem[19:DEPTH_LOG2+4]};
    assign accept = state == IDLE && reqI_mem;
    assign fire = state == WAIT && cnt == 4'd0;
    assign read_ready_from_mem = fire && !wr_q;
    assign written_data_ack_from_mem = fire && wr_q;
    assign busy = state != IDLE;
    // Read data is registered one edge ahead of the pulse so it is valid for the whole pulse cycle.
    assign load_rd = (accept && !req_wr && LATENCY == 1) || (state == WAIT && cnt == 4'd1 && !wr_q);
    assign rd_idx = state == IDLE ? req_idx : idx;
    always_comb begin
        state_nxt = accept ? WAIT : fire ? DONE : (state == DONE && !reqI_mem) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            idx <= '0;
            wr_q <= 1'b0;
            wdata_q <= '0;
            instr_from_mem <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= 4'(LATENCY - 1);
                idx <= req_idx;
                wr_q <= req_wr;
                wdata_q <= write_data;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (load_rd) instr_from_mem <= mem[rd_idx];
        end
    end
    // Array has no reset so its contents survive reset.
    always_ff @(posedge clk) begin
        if (fire && wr_q) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: directed vector bench for instr_mem_responder at LATENCY 5 and LATENCY 1.
module tb_instr_mem_responder;
    typedef struct packed {
        logic [19:0]  addr;
        logic         wr;
        logic [127:0] wdata;
        logic [127:0] exp;
        logic         ack;
        int           hold;
    } vec_t;

    localparam logic [127:0] L_A5 = {16{8'hA5}};
    localparam logic [127:0] L_2  = {8{16'h2222}};
    localparam logic [127:0] L_7  = {16{8'h77}};
    localparam logic [127:0] L_16 = {16{8'h16}};
    localparam logic [127:0] L_W  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] L_B  = {8{16'hBEEF}};
    localparam logic [127:0] L_C0 = {16{8'hC0}};
    localparam logic [127:0] L_C1 = {16{8'hC1}};

    logic clk = 1'b0, reset = 1'b1;
    logic req = 1'b0, wr = 1'b0;
    logic [19:0] addr = '0;
    logic [127:0] wdata = '0, rdata;
    logic rr, ack, busy;
    logic req1 = 1'b0;
    logic [19:0] addr1 = '0;
    logic [127:0] rdata1;
    logic rr1, ack1, busy1;
    int n_checks = 0, n_fail = 0, both = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    instr_mem_responder #(.LATENCY(5), .DEPTH_LOG2(10)) u_d5 (
        .clk(clk), .reset(reset), .reqI_mem(req), .reqAddrI_mem(addr), .req_write(wr),
        .write_data(wdata), .instr_from_mem(rdata), .read_ready_from_mem(rr),
        .written_data_ack_from_mem(ack), .busy(busy)
    );

    instr_mem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) u_d1 (
        .clk(clk), .reset(reset), .reqI_mem(req1), .reqAddrI_mem(addr1), .req_write(1'b0),
        .write_data(128'd0), .instr_from_mem(rdata1), .read_ready_from_mem(rr1),
        .written_data_ack_from_mem(ack1), .busy(busy1)
    );

    always @(negedge clk) begin
        if ((rr && ack) || (rr1 && ack1)) both++;
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Issue one request, scramble the inputs while it is in flight, then hold it for v.hold cycles.
    task automatic xact(input vec_t v, input string nm);
        int lat, extra, idle;
        lat = 1; extra = 0; idle = 0;
        addr = v.addr; wr = v.wr; wdata = v.wdata; req = 1'b1;
        @(negedge clk);
        addr = ~v.addr; wr = ~v.wr; wdata = ~v.wdata;
        while (!(rr || ack) && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, 5);
        check({nm, " ack"}, ack, v.ack);
        check({nm, " read_ready"}, rr, !v.ack);
        if (!v.ack) check({nm, " data"}, rdata, v.exp);
        repeat (v.hold) begin
            @(negedge clk);
            if (rr || ack) extra++;
            if (!busy) idle++;
        end
        check({nm, " extra pulses"}, extra, 0);
        check({nm, " busy drops while held"}, idle, 0);
        if (!v.ack) check({nm, " data held"}, rdata, v.exp);
        req = 1'b0;
        @(negedge clk);
        check({nm, " idle after release"}, busy, 0);
    endtask

    initial begin
        int pulses;
        u_d5.mem[4] <= L_A5;
        u_d5.mem[2] <= L_2;
        u_d5.mem[7] <= L_7;
        u_d5.mem[16] <= L_16;
        u_d1.mem[0] <= L_C0;
        u_d1.mem[1] <= L_C1;
        vecs.push_back('{20'h00040, 1'b0, '0, L_A5, 1'b0, 2});
        vecs.push_back('{20'h0004F, 1'b0, '0, L_A5, 1'b0, 20});
        vecs.push_back('{20'hFC040, 1'b0, '0, L_A5, 1'b0, 2});
`ifdef IMEM_RESP_WRITE_EN
        vecs.push_back('{20'h00100, 1'b1, L_W, '0, 1'b1, 2});
        vecs.push_back('{20'h0010C, 1'b0, '0, L_W, 1'b0, 2});
        vecs.push_back('{20'h00020, 1'b1, L_B, '0, 1'b1, 3});
        vecs.push_back('{20'h00020, 1'b0, '0, L_B, 1'b0, 2});
`else
        vecs.push_back('{20'h00020, 1'b1, L_B, L_2, 1'b0, 2});
        vecs.push_back('{20'h00020, 1'b0, '0, L_2, 1'b0, 2});
        vecs.push_back('{20'h00100, 1'b1, L_W, L_16, 1'b0, 2});
`endif
        @(negedge clk);
        check("reset d5 outputs", {rdata, rr, ack, busy}, '0);
        check("reset d1 outputs", {rdata1, rr1, ack1, busy1}, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        foreach (vecs[i]) xact(vecs[i], $sformatf("vec%0d", i));

        // Abort a request to line 7 with reset two cycles after acceptance.
        addr = 20'h00070; wr = 1'b1; wdata = {16{8'hDE}}; req = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort outputs", {rdata, rr, ack, busy}, '0);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (rr || ack || busy) pulses++;
        end
        check("abort no activity", pulses, 0);
        xact('{20'h00070, 1'b0, '0, L_7, 1'b0, 1}, "line7 after abort");

        // LATENCY 1 back-to-back reads with a single low cycle between them.
        addr1 = 20'h00000; req1 = 1'b1;
        @(negedge clk);
        check("lat1 first pulse", {rr1, ack1}, 2'b10);
        check("lat1 first data", rdata1, L_C0);
        addr1 = 20'h00010;
        @(negedge clk);
        check("lat1 done state", {rr1, busy1}, 2'b01);
        req1 = 1'b0;
        @(negedge clk);
        check("lat1 gap idle", busy1, 0);
        req1 = 1'b1;
        @(negedge clk);
        check("lat1 second pulse", {rr1, ack1}, 2'b10);
        check("lat1 second data", rdata1, L_C1);
        req1 = 1'b0;
        @(negedge clk);
        check("lat1 second no repeat", rr1, 0);
        check("lat1 data held", rdata1, L_C1);
        @(negedge clk);
        check("pulse exclusivity", both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter LATENCY, default 5, cycles from request acceptance to response pulse; legal range 1..15.
REQ-002 Parameter DEPTH_LOG2, default 10, log2 of the number of 128-bit lines in the backing array.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 reqI_mem  input  1  line request from the instruction cache; held high until serviced.
REQ-006 reqAddrI_mem  input  20  byte address of the requested line.
REQ-007 req_write  input  1  1 = line write, 0 = line read; sampled with reqI_mem.
REQ-008 write_data  input  128  line to store on a write; sampled at acceptance.
REQ-009 instr_from_mem  output  128  read line; valid while read_ready_from_mem is high; holds its value afterwards.
REQ-010 read_ready_from_mem  output  1  one-cycle pulse marking read completion.
REQ-011 written_data_ack_from_mem  output  1  one-cycle pulse marking write completion.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 Line index = reqAddrI_mem[DEPTH_LOG2+3:4]; bits [3:0] and bits above the index are ignored.
REQ-014 FSM states: IDLE, WAIT, DONE.
REQ-015 IDLE with reqI_mem=1 at an edge: capture index, req_write and write_data; load the 4-bit counter with LATENCY-1; go to WAIT.
REQ-016 WAIT with counter>0: decrement the counter each cycle.
REQ-017 WAIT with counter=0, captured read: drive instr_from_mem = array[index], pulse read_ready_from_mem for one cycle, go to DONE.
REQ-018 WAIT with counter=0, captured write: store the captured data at the captured index, pulse written_data_ack_from_mem for one cycle, go to DONE.
REQ-019 Latency: a request accepted at edge T produces its pulse in the cycle following edge T+LATENCY-1; with LATENCY=1 the pulse appears in the cycle after acceptance.
REQ-020 DONE: stay while reqI_mem=1; go to IDLE when reqI_mem=0, so a held request is never serviced twice.
REQ-021 Changes on reqAddrI_mem, req_write or write_data during WAIT or DONE have no effect.
REQ-022 Only one request is outstanding at a time; there is no queuing.
REQ-023 The two completion pulses are mutually exclusive and never assert in the same cycle.
REQ-024 A read of a line written by the immediately preceding transaction returns the new data.

Reset
REQ-025 Asserting reset at any time forces IDLE, counter 0, instr_from_mem 0, read_ready_from_mem 0, written_data_ack_from_mem 0 and busy 0.
REQ-026 Reset during WAIT aborts the transaction: no pulse is generated and no array write occurs.
REQ-027 The array contents are not cleared by reset.
REQ-028 The first request after reset is accepted on the first edge with reqI_mem=1 after reset deasserts.

Configuration
REQ-029 Macro IMEM_RESP_WRITE_EN: when defined, line writes behave per REQ-018.
REQ-030 Without IMEM_RESP_WRITE_EN: req_write is ignored and every request is serviced as a read; written_data_ack_from_mem is tied 0 and the array is never written after initialisation.

Verification
REQ-031 LATENCY=5; read of addr 0x00040 with array[4]=0xA5..A5 (all bytes 0xA5) -> read_ready pulses exactly 5 cycles after acceptance, instr_from_mem=0xA5..A5, then busy=1 until reqI_mem drops.
REQ-032 IMEM_RESP_WRITE_EN defined: write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to addr 0x00100, then read addr 0x0010C -> one ack pulse, then a read pulse returning the same 128-bit value.
REQ-033 reqI_mem held high for 20 cycles after the read pulse -> exactly one read_ready pulse; the next request is accepted only after reqI_mem drops.
REQ-034 Reset asserted 2 cycles after accepting a write to line 7 -> no ack pulse, all outputs 0, and a later read of line 7 returns its pre-write value.
REQ-035 LATENCY=1, back-to-back reads of addr 0x00000 and 0x00010 with a one-cycle reqI_mem low gap -> each pulse one cycle after its acceptance.
REQ-036 Without IMEM_RESP_WRITE_EN: write request to addr 0x00020 -> serviced as a read, written_data_ack_from_mem stays 0, array[2] unchanged.
